// File: rtl/adder_sweep_checker.sv
// Exhaustive clocked driver/monitor for a WIDTH-bit ripple adder.
// Sweeps every {cin,a,b}, holds SETTLE cycles, checks sum/co against a + b + cin.
module adder_sweep_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 cin,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 co,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   check_count,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     first_fail_vec,
  output logic                 first_fail_valid
);

  localparam int VW = 2*WIDTH+1;
  localparam int CW = 2*WIDTH+2;

  localparam logic [VW-1:0] VMAX   = '1;
  localparam logic [3:0]    RELOAD = 4'(SETTLE-1);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   v_q, v_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [CW-1:0]   chk_q, chk_d;
  logic [CW-1:0]   err_q, err_d;
  logic [VW-1:0]   ffv_q, ffv_d;
  logic            ffval_q, ffval_d;

  logic [WIDTH:0]  exp_w;
  logic            mismatch;

  // Operands come straight off the vector register, so they stay registered.
  assign cin = v_q[2*WIDTH];
  assign a   = v_q[2*WIDTH-1:WIDTH];
  assign b   = v_q[WIDTH-1:0];

  // Full WIDTH+1 reference; carry-out is compared, never truncated away.
  assign exp_w = {1'b0, a}
               + {1'b0, b}
               + {{WIDTH{1'b0}}, cin};

  assign mismatch = ({co, sum} != exp_w);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffval_d = ffval_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          v_d     = '0;
          chk_d   = '0;
          err_d   = '0;
          ffv_d   = '0;
          ffval_d = 1'b0;
          cnt_d   = RELOAD;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (cnt_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        chk_d = chk_q + CW'(1);
        if (mismatch) begin
          err_d = err_q + CW'(1);
          if (!ffval_q) begin
            ffv_d   = {cin, a, b};
            ffval_d = 1'b1;
          end
        end
        if (v_q == VMAX) begin
          state_d = DONE;
        end else begin
          v_d     = v_q + VW'(1);
          cnt_d   = RELOAD;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffval_q <= ffval_d;
    end
  end

  assign busy = (state_q == APPLY)
             || (state_q == CHECK);
  assign done = (state_q == DONE);
  assign pass = done && (err_q == '0);

  assign check_count      = chk_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker: behavioural adder with injectable faults,
// per-cycle operand tracking and a per-sweep result scoreboard.
module tb_adder_sweep_checker;

  localparam int W   = 4;
  localparam int ST  = 2;
  localparam int NV  = 1 << (2*W+1);
  localparam int LAT = NV * (ST+1);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [W-1:0]    a, b, sum;
  logic            cin, co;
  logic            busy, done, pass;
  logic [2*W+1:0]  check_count, err_count;
  logic [2*W:0]    first_fail_vec;
  logic            first_fail_valid;

  int              fault;
  logic [W:0]      full;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int   cc;
    int   ec;
    int   ps;
    int   ffv;
    int   ffval;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  adder_sweep_checker #(.WIDTH(W), .SETTLE(ST)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .a                (a),
    .b                (b),
    .cin              (cin),
    .sum              (sum),
    .co               (co),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .check_count      (check_count),
    .err_count        (err_count),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  // Adder under test: 0 = good, 1 = co stuck at 0, 2 = sum[0] inverted
  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  always_comb begin
    co  = full[W];
    sum = full[W-1:0];
    if (fault == 1) co = 1'b0;
    if (fault == 2) sum = full[W-1:0] ^ W'(1);
  end

  task automatic expect_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all_zero(input string tag);
    expect_eq({tag, "_ops"}, int'({cin, a, b}), 0);
    expect_eq({tag, "_busy"}, int'(busy), 0);
    expect_eq({tag, "_done"}, int'(done), 0);
    expect_eq({tag, "_pass"}, int'(pass), 0);
    expect_eq({tag, "_cc"}, int'(check_count), 0);
    expect_eq({tag, "_ec"}, int'(err_count), 0);
    expect_eq({tag, "_ffv"}, int'(first_fail_vec), 0);
    expect_eq({tag, "_ffval"}, int'(first_fail_valid), 0);
  endtask

  task automatic push_expected(input int fm);
    exp_t e;
    int   s, gco, gsum, oco, osum;
    e = '{cc: NV, ec: 0, ps: 0, ffv: 0, ffval: 0};
    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < (1 << W); ai++)
        for (int bi = 0; bi < (1 << W); bi++) begin
          s    = ai + bi + ci;
          gco  = s / (1 << W);
          gsum = s % (1 << W);
          oco  = (fm == 1) ? 0 : gco;
          osum = (fm == 2) ? (gsum ^ 1) : gsum;
          if (oco != gco || osum != gsum) begin
            if (e.ffval == 0) begin
              e.ffv   = (ci << (2*W)) | (ai << W) | bi;
              e.ffval = 1;
            end
            e.ec++;
          end
        end
    e.ps = (e.ec == 0) ? 1 : 0;
    sbq.push_back(e);
  endtask

  task automatic run_sweep(input string tag, input int fm, input bit hold);
    exp_t e;
    int   k;
    fault = fm;
    push_expected(fm);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    k = 0;
    while (!done && k < LAT + 64) begin
      if (k % (ST+1) == 0) begin
        expect_eq({tag, "_vec"}, int'({cin, a, b}), k / (ST+1));
        expect_eq({tag, "_busy"}, int'(busy), 1);
      end
      tick();
      k++;
    end
    expect_eq({tag, "_lat"}, k, LAT);
    expect_eq({tag, "_busy_done"}, int'(busy), 0);
    expect_eq({tag, "_last_ops"}, int'({cin, a, b}), NV-1);
    e = sbq.pop_front();
    expect_eq({tag, "_cc"}, int'(check_count), e.cc);
    expect_eq({tag, "_ec"}, int'(err_count), e.ec);
    expect_eq({tag, "_pass"}, int'(pass), e.ps);
    expect_eq({tag, "_ffv"}, int'(first_fail_vec), e.ffv);
    expect_eq({tag, "_ffval"}, int'(first_fail_valid), e.ffval);
  endtask

  initial begin
    fault = 0;
    rst   = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_all_zero("rst");
    end
    rst = 1'b0;

    run_sweep("golden", 0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    expect_eq("hold_done", int'(done), 1);
    expect_eq("hold_cc", int'(check_count), NV);

    run_sweep("co_stuck", 1, 1'b0);
    run_sweep("sum0_inv", 2, 1'b0);

    fault = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    expect_eq("mid_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_all_zero("midrst");
    tick();
    expect_eq("midrst_idle", int'(busy), 0);
    run_sweep("after_rst", 0, 1'b0);

    run_sweep("held", 0, 1'b1);
    run_sweep("repulse", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_sweep_checker.md
# adder_sweep_checker

Self-checking stimulus engine for the team's WIDTH-bit ripple adder. It drives the adder's `a`/`b`/`cin` inputs through every combination, waits a programmable settle time, and compares `sum`/`co` against an internal reference. It counts checks and mismatches and reports pass/fail. It sits on the other side of the adder interface as the driver-plus-monitor, replacing hand-written delay stimulus with a synthesizable, clocked sweep.

## Interface
- `WIDTH`, default 4: operand width; the vector space is 2^(2*WIDTH+1).
- `SETTLE`, default 2: cycles operands are held before sampling; legal range is 1..15.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; honoured only in IDLE or DONE.
- `a`  out  WIDTH  operand A to the adder; registered.
- `b`  out  WIDTH  operand B to the adder; registered.
- `cin`  out  1  carry-in to the adder; registered.
- `sum`  in  WIDTH  adder sum, sampled in CHECK.
- `co`  in  1  adder carry-out, sampled in CHECK.
- `busy`  out  1  high in APPLY and CHECK.
- `done`  out  1  high while in DONE.
- `pass`  out  1  high in DONE when `err_count` is 0; 0 otherwise.
- `check_count`  out  2*WIDTH+2  number of vectors compared.
- `err_count`  out  2*WIDTH+2  number of mismatching vectors.
- `first_fail_vec`  out  2*WIDTH+1  {cin,a,b} of the first mismatch.
- `first_fail_valid`  out  1  `first_fail_vec` holds a captured value.

## Operation
- Vector index `v` is 2*WIDTH+1 bits, mapped as `cin`=v[2W], `a`=v[2W-1:W], `b`=v[W-1:0]. `b` is the fastest-changing field.
- Reference computation: {exp_co, exp_sum} = a + b + cin, evaluated at WIDTH+1 bits with no truncation before the compare. A mismatch is (sum != exp_sum) or (co != exp_co).
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE, or DONE with `start`=1:
  - clear `v`, both counts, `first_fail_*` and `pass`;
  - drive `a`/`b`/`cin` from v=0;
  - load the settle counter with SETTLE-1;
  - go to APPLY.
- APPLY: hold the operands and decrement the counter. When the counter is 0, go to CHECK.
- CHECK:
  - increment `check_count`;
  - on a mismatch, increment `err_count`; if `first_fail_valid`=0, capture {cin,a,b} and set `first_fail_valid`.
  - If `v` is at its maximum value, go to DONE.
  - Otherwise increment `v`, register the new operands, reload the counter with SETTLE-1, and go to APPLY.
- DONE: hold all results. `done`=1 and `pass`=(err_count==0). Stay in DONE until `start` or `rst`.
- `start` while busy is ignored. It has no effect on counters or timing.
- Counts cannot saturate; the width is chosen so a full sweep (2^(2W+1)) fits exactly.

## Timing
- Reset: on the edge where `rst`=1, the FSM goes to IDLE and every output is 0: `a`, `b`, `cin`, `busy`, `done`, `pass`, both counts, `first_fail_vec`, `first_fail_valid`. `rst` overrides `start` and takes effect at any point, including mid-sweep.
- `start` sampled high at edge N:
  - vector 0 is on `a`/`b`/`cin` after edge N;
  - `busy` is 1 after edge N.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in APPLY, then 1 in CHECK.
- `sum`/`co` are sampled at the edge that leaves CHECK. The operands have been stable for SETTLE+1 edges at that point; the adder is combinational.
- DONE is entered at edge N + 2^(2W+1)*(SETTLE+1). With defaults that is N+1536:
  - `busy` falls and `done`/`pass` rise at that same edge;
  - `check_count` = 512.
- Operands keep the last vector's value in DONE.

## Test plan
- Reset values: hold `rst` for 3 cycles with `start`=1 -> all outputs 0 and the FSM stays in IDLE; after release, `busy`=1 exactly one cycle after the first sampled `start`.
- Golden sweep: correct adder, defaults, pulse `start` -> `done` 1536 cycles after the start edge; `check_count`=512, `err_count`=0, `pass`=1, `first_fail_valid`=0.
- Stuck `co`=0 fault -> `err_count`=256, `pass`=0, `first_fail_vec`=9'h01F (a=1, b=15, cin=0).
- `sum[0]` inverted fault -> `err_count`=512, `first_fail_vec`=9'h000.
- Mid-sweep reset: assert `rst` 100 cycles after start -> all outputs 0 on the next cycle; re-`start` completes a full 512-vector sweep with correct counts.
- `start` held high for the whole sweep, then re-pulsed in DONE:
  - while busy, no effect, and `done` still arrives at +1536;
  - the pulse in DONE clears the counts and restarts, and the second run gives identical results.
